// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller for the five-stage MIPS core (M stage).
// Holds SR/Cause/EPC/PrID, raises int_req for exceptions and enabled
// hardware interrupts, and supplies the eret return address.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID         = 32'h0000_2018,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  a_wr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic        exl_clr,
  input  logic [5:0]  hwint,
  output logic        int_req,
  output logic [31:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // SR fields
  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  // Cause fields
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_exc_q, cause_exc_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        irq;
  logic        exc;
  logic [31:0] pc_aligned;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Request is purely combinational; nested requests are masked by EXL and
  // everything is held off while reset is asserted.
  always_comb begin
    irq     = (|(hwint & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    exc     = (exccode_m != 5'd0) & ~sr_exl_q;
    int_req = (irq | exc) & reset;
  end

  // Next-state: one action per edge, int_req > exl_clr > mtc0.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = hwint;
    pc_aligned  = {pc_m[31:2], 2'b00};
    if (int_req) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = irq ? 5'd0 : exccode_m;
      cause_bd_d  = bd_m;
      // A delay-slot instruction must restart at its branch.
      epc_d       = bd_m ? (pc_aligned - 32'd4) : pc_aligned;
    end else if (exl_clr) begin
      sr_exl_d = 1'b0;
    end else if (we) begin
      if (a_wr == REG_SR) begin
        sr_im_d  = din[15:10];
        sr_exl_d = din[1];
        sr_ie_d  = din[0];
      end else if (a_wr == REG_EPC) begin
        epc_d = din;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // Read mux and EPC forward so mtc0 EPC directly followed by eret works.
  always_comb begin
    sr_word    = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
    cause_word = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
    epc        = (we && (a_wr == REG_EPC) && !int_req) ? din : epc_q;
    case (a_rd)
      REG_SR:    dout = sr_word;
      REG_CAUSE: dout = cause_word;
      REG_EPC:   dout = epc_q;
      REG_PRID:  dout = PRID;
      default:   dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed, table-driven bench for cp0_exc_ctrl.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  a_rd;
  logic [4:0]  a_wr;
  logic [31:0] din;
  logic        we;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exccode_m;
  logic        exl_clr;
  logic [5:0]  hwint;
  logic        int_req;
  logic [31:0] epc;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .a_rd(a_rd), .a_wr(a_wr), .din(din), .we(we),
    .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m), .exl_clr(exl_clr),
    .hwint(hwint), .int_req(int_req), .epc(epc), .dout(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a_rd;
    logic [4:0]  a_wr;
    logic [31:0] din;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exccode;
    logic        exl_clr;
    logic [5:0]  hwint;
    logic        exp_req;
    logic [31:0] exp_epc;
    logic [31:0] exp_dout;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] rd, input logic [4:0] wr,
                              input logic [31:0] d, input logic w,
                              input logic [31:0] pc, input logic bd,
                              input logic [4:0] ec, input logic clr,
                              input logic [5:0] hw, input logic xr,
                              input logic [31:0] xe, input logic [31:0] xd);
    vec_t v;
    v.a_rd = rd; v.a_wr = wr; v.din = d; v.we = w; v.pc_m = pc; v.bd_m = bd;
    v.exccode = ec; v.exl_clr = clr; v.hwint = hw;
    v.exp_req = xr; v.exp_epc = xe; v.exp_dout = xd;
    return v;
  endfunction

  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b want %0b", name, got, want);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  task automatic idle();
    a_rd = 5'd0; a_wr = 5'd0; din = 32'd0; we = 1'b0; pc_m = 32'd0;
    bd_m = 1'b0; exccode_m = 5'd0; exl_clr = 1'b0; hwint = 6'd0;
  endtask

  initial begin
    //             rd  wr  din           we  pc_m          bd ec  clr hwint      req epc           dout
    vecs[0]  = mk(12, 12, 32'h0000_0401, 1, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0,        32'h0);
    vecs[1]  = mk(12, 0,  32'h0,         0, 32'h0000_3040,0, 0,  0, 6'b000001, 1, 32'h0,        32'h0000_0401);
    vecs[2]  = mk(13, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000001, 0, 32'h0000_3040,32'h0000_0400);
    vecs[3]  = mk(12, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3040,32'h0000_0403);
    vecs[4]  = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  1, 6'b000000, 0, 32'h0000_3040,32'h0000_3040);
    vecs[5]  = mk(12, 0,  32'h0,         0, 32'h0000_3002,0, 4,  0, 6'b000000, 1, 32'h0000_3040,32'h0000_0401);
    vecs[6]  = mk(13, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3000,32'h0000_0010);
    vecs[7]  = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  1, 6'b000000, 0, 32'h0000_3000,32'h0000_3000);
    vecs[8]  = mk(12, 0,  32'h0,         0, 32'h0000_3010,1, 8,  0, 6'b000000, 1, 32'h0000_3000,32'h0000_0401);
    vecs[9]  = mk(13, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_300C,32'h8000_0020);
    vecs[10] = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  1, 6'b000000, 0, 32'h0000_300C,32'h0000_300C);
    vecs[11] = mk(12, 12, 32'h0000_1401, 1, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_300C,32'h0000_0401);
    vecs[12] = mk(12, 12, 32'h0,         1, 32'h0000_3020,0, 10, 0, 6'b000100, 1, 32'h0000_300C,32'h0000_1401);
    vecs[13] = mk(13, 0,  32'h0,         0, 32'h0,        0, 12, 0, 6'b000100, 0, 32'h0000_3020,32'h0000_1000);
    vecs[14] = mk(12, 0,  32'h0,         0, 32'h0,        0, 12, 0, 6'b000100, 0, 32'h0000_3020,32'h0000_1403);
    vecs[15] = mk(12, 0,  32'h0,         0, 32'h0,        0, 0,  1, 6'b000100, 0, 32'h0000_3020,32'h0000_1403);
    vecs[16] = mk(12, 0,  32'h0,         0, 32'h0000_3030,0, 0,  0, 6'b000100, 1, 32'h0000_3020,32'h0000_1401);
    vecs[17] = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3030,32'h0000_3030);
    vecs[18] = mk(14, 14, 32'h0000_3400, 1, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3400,32'h0000_3030);
    vecs[19] = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  1, 6'b000000, 0, 32'h0000_3400,32'h0000_3400);
    vecs[20] = mk(15, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3400,32'h0000_2018);
    vecs[21] = mk(7,  13, 32'hFFFF_FFFF, 1, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3400,32'h0);
    vecs[22] = mk(13, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3400,32'h0);
    vecs[23] = mk(14, 14, 32'h5555_0000, 1, 32'h0000_3050,0, 4,  0, 6'b000000, 1, 32'h0000_3400,32'h0000_3400);
    vecs[24] = mk(14, 0,  32'h0,         0, 32'h0,        0, 0,  0, 6'b000000, 0, 32'h0000_3050,32'h0000_3050);

    // Reset state, with a pending exception code that must not fire.
    idle();
    reset = 1'b0;
    exccode_m = 5'd4;
    a_rd = 5'd12;
    #12;
    chk1("reset int_req", int_req, 1'b0);
    chk32("reset epc", epc, 32'h0);
    chk32("reset SR", dout, 32'h0);
    a_rd = 5'd13; #1;
    chk32("reset Cause", dout, 32'h0);
    $display("reset: int_req=%0b epc=%08h cause=%08h", int_req, epc, dout);
    exccode_m = 5'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_rd = vecs[i].a_rd; a_wr = vecs[i].a_wr; din = vecs[i].din;
      we = vecs[i].we; pc_m = vecs[i].pc_m; bd_m = vecs[i].bd_m;
      exccode_m = vecs[i].exccode; exl_clr = vecs[i].exl_clr; hwint = vecs[i].hwint;
      #1;
      chk1($sformatf("vec%0d int_req", i), int_req, vecs[i].exp_req);
      chk32($sformatf("vec%0d epc", i), epc, vecs[i].exp_epc);
      chk32($sformatf("vec%0d dout", i), dout, vecs[i].exp_dout);
      $display("vec%0d: rd=%0d we=%0b ec=%0d hw=%b -> int_req=%0b epc=%08h dout=%08h",
               i, a_rd, we, exccode_m, hwint, int_req, epc, dout);
    end

    // Asynchronous reset in the middle of a handler (EXL is 1 here).
    @(negedge clk);
    idle();
    a_rd = 5'd12;
    #1;
    chk32("pre-reset SR has EXL", dout, 32'h0000_1403);
    exccode_m = 5'd4;
    #1;
    reset = 1'b0;
    #1;
    chk1("midreset int_req", int_req, 1'b0);
    chk32("midreset SR", dout, 32'h0);
    chk32("midreset epc", epc, 32'h0);
    a_rd = 5'd13; #1;
    chk32("midreset Cause", dout, 32'h0);
    $display("mid-handler reset: int_req=%0b epc=%08h", int_req, epc);
    exccode_m = 5'd0;
    @(negedge clk);
    #2 reset = 1'b1;

    // With EXL cleared by reset, an exception fires again even though IE=0.
    exccode_m = 5'd4;
    #1;
    chk1("post-reset exc int_req", int_req, 1'b1);
    #1 exccode_m = 5'd0;

    // SR write masks out unimplemented bits.
    @(negedge clk);
    we = 1'b1; a_wr = 5'd12; din = 32'hFFFF_FFFF;
    @(negedge clk);
    we = 1'b0; a_rd = 5'd12; hwint = 6'b111111;
    #1;
    chk32("SR mask", dout, 32'h0000_FC03);
    chk1("EXL blocks irq", int_req, 1'b0);
    $display("SR mask: dout=%08h int_req=%0b", dout, int_req);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
